nonce_batch_scheduler: RTL

NONCE_BATCH_SCHEDULER -- requirements
Module: nonce_batch_scheduler

---
 rtl/nonce_batch_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/nonce_batch_scheduler.sv
// Nonce batch scheduler: splits a mining job into fixed-size hash-core batches,
// launches each batch, collects the in-order result beats, tracks hits against
// the target, and guards each batch with a beat watchdog.
module nonce_batch_scheduler #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] nonce_base,
  input  logic [7:0]  batch_count,
  input  logic [31:0] target,
  input  logic        stop_on_hit,
  output logic        core_start,
  output logic [31:0] core_nonce_base,
  input  logic        res_valid,
  input  logic [31:0] res_h0,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [15:0] hit_count,
  output logic [7:0]  batches_done
);

  // Beat index covers 0..NUM_NONCES-1; watchdog covers 0..TIMEOUT-1.
  localparam int unsigned BEAT_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_NONCES - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [31:0]       NONCE_STEP = 32'(NUM_NONCES);
  localparam logic [15:0]       HIT_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_NEXT    = 3'd3,
    ST_FINISH  = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // Job parameters captured on an accepted start.
  logic [7:0]  count_q;
  logic [31:0] target_q;
  logic        stop_q;

  // Per-batch progress.
  logic [BEAT_W-1:0] beat_idx;
  logic [WD_W-1:0]   wd_cnt;

  // Combinational helpers.
  logic        accept_c;
  logic        beat_c;
  logic        hit_c;
  logic        last_beat_c;
  logic        wd_expire_c;
  logic        job_end_c;
  logic [31:0] beat_nonce_c;

  assign accept_c     = (state_q == ST_IDLE) && start;
  assign beat_c       = (state_q == ST_COLLECT) && res_valid;
  assign hit_c        = res_h0 < target_q;
  assign last_beat_c  = beat_idx == LAST_BEAT;
  assign wd_expire_c  = wd_cnt == WD_LAST;
  // Wrapping 8-bit compare: a sampled count of 0 matches after 256 batches.
  assign job_end_c    = (batches_done == count_q) || (stop_q && found);
  assign beat_nonce_c = core_nonce_base + 32'(beat_idx);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (res_valid) begin
          if (last_beat_c) begin
            state_d = ST_NEXT;
          end
        end else if (wd_expire_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_NEXT: begin
        state_d = job_end_c ? ST_FINISH : ST_LAUNCH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered strobes and status, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_start <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_start <= state_d == ST_LAUNCH;
      done       <= state_d == ST_FINISH;
      busy       <= state_d != ST_IDLE;
    end
  end

  // Job parameter capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 8'd0;
      target_q <= 32'd0;
      stop_q   <= 1'b0;
    end else if (accept_c) begin
      count_q  <= batch_count;
      target_q <= target;
      stop_q   <= stop_on_hit;
    end
  end

  // Batch base nonce: loaded on start, advanced by one batch on each relaunch.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_nonce_base <= 32'd0;
    end else if (accept_c) begin
      core_nonce_base <= nonce_base;
    end else if ((state_q == ST_NEXT) && (state_d == ST_LAUNCH)) begin
      core_nonce_base <= core_nonce_base + NONCE_STEP;
    end
  end

  // Beat index and watchdog; both restart at every launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx <= '0;
      wd_cnt   <= '0;
    end else if (state_q == ST_LAUNCH) begin
      beat_idx <= '0;
      wd_cnt   <= '0;
    end else if (state_q == ST_COLLECT) begin
      if (res_valid) begin
        beat_idx <= beat_idx + BEAT_W'(1);
        wd_cnt   <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  // Hit tracking: first-hit nonce plus a saturating hit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      found       <= 1'b0;
      found_nonce <= 32'd0;
      hit_count   <= 16'd0;
    end else if (accept_c) begin
      found       <= 1'b0;
      found_nonce <= 32'd0;
      hit_count   <= 16'd0;
    end else if (beat_c && hit_c) begin
      if (hit_count != HIT_MAX) begin
        hit_count <= hit_count + 16'd1;
      end
      if (!found) begin
        found       <= 1'b1;
        found_nonce <= beat_nonce_c;
      end
    end
  end

  // Completed batch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      batches_done <= 8'd0;
    end else if (accept_c) begin
      batches_done <= 8'd0;
    end else if (beat_c && last_beat_c) begin
      batches_done <= batches_done + 8'd1;
    end
  end

  // Sticky watchdog flag, cleared only by a new job or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (accept_c) begin
      error <= 1'b0;
    end else if ((state_q == ST_COLLECT) && (state_d == ST_FAULT)) begin
      error <= 1'b1;
    end
  end

endmodule
